// File: rtl/mult_seq_ctrl.sv
// Sequencing controller for a WIDTH x WIDTH shift-add multiplier datapath.
// Optional macro MULT_CTRL_SKIP_ZERO_EN: shift in the ADD cycle when b_lsb=0 and bypass SHIFT.
module mult_seq_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic b_lsb,
    output logic busy,
    output logic done,
    output logic clr_acc,
    output logic ld_A,
    output logic ld_B,
    output logic add_en,
    output logic shift_en,
    output logic ld_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ADD   = 3'd2,
        S_SHIFT = 3'd3,
        S_STORE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            clr_acc_q, clr_acc_d;
    logic            ld_a_q, ld_a_d;
    logic            ld_b_q, ld_b_d;
    logic            shift_q, shift_d;
    logic            ld_out_q, ld_out_d;
    logic            skip_shift_s;

    // Next-state and step-counter logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        skip_shift_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                cnt_d   = {CW{1'b0}};
                state_d = S_ADD;
            end
            S_ADD: begin
`ifdef MULT_CTRL_SKIP_ZERO_EN
                // A zero multiplier bit needs no add, so shift right away.
                if (!b_lsb) begin
                    skip_shift_s = 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_STORE;
                    end else begin
                        cnt_d   = cnt_q + CNT_ONE;
                        state_d = S_ADD;
                    end
                end else begin
                    state_d = S_SHIFT;
                end
`else
                state_d = S_SHIFT;
`endif
            end
            S_SHIFT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_STORE;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                    state_d = S_ADD;
                end
            end
            S_STORE: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = {CW{1'b0}};
            end
        endcase
    end

    // Moore outputs decoded from the next state so they are registered with it
    always_comb begin
        busy_d    = (state_d != S_IDLE);
        ld_a_d    = (state_d == S_LOAD);
        ld_b_d    = (state_d == S_LOAD);
        clr_acc_d = (state_d == S_LOAD);
        shift_d   = (state_d == S_SHIFT);
        ld_out_d  = (state_d == S_STORE);
        done_d    = (state_d == S_DONE);
    end

    // State, counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= {CW{1'b0}};
            busy_q    <= 1'b0;
            ld_a_q    <= 1'b0;
            ld_b_q    <= 1'b0;
            clr_acc_q <= 1'b0;
            shift_q   <= 1'b0;
            ld_out_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            ld_a_q    <= ld_a_d;
            ld_b_q    <= ld_b_d;
            clr_acc_q <= clr_acc_d;
            shift_q   <= shift_d;
            ld_out_q  <= ld_out_d;
            done_q    <= done_d;
        end
    end

    // b_lsb arrives in the ADD cycle itself, so add_en must stay combinational.
    assign add_en   = (state_q == S_ADD) & b_lsb;
    assign shift_en = shift_q | skip_shift_s;
    assign busy     = busy_q;
    assign done     = done_q;
    assign clr_acc  = clr_acc_q;
    assign ld_A     = ld_a_q;
    assign ld_B     = ld_b_q;
    assign ld_out   = ld_out_q;

endmodule

// File: doc/mult_seq_ctrl.md
# mult_seq_ctrl

Sequencing controller for the 4x4 shift-add multiplier datapath. It accepts a start request, loads the operands, and runs one add-then-shift step per multiplier bit, gated by the multiplier LSB returned from the datapath. It then loads the product register and reports completion with a one-cycle `done` pulse. It sits beside the datapath in the top-level multiplier and drives all of its load, clear, add and shift controls.

## Interface
- `WIDTH`, default 4: operand width, equal to the number of add/shift steps; legal range 2..16.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request to begin a multiply; level, sampled only in IDLE.
- `b_lsb`  in  1  current LSB of the datapath multiplier (B) shift register.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse; the product register is valid from this cycle on.
- `clr_acc`  out  1  clears the datapath accumulator / upper product half.
- `ld_A`  out  1  loads the A operand register.
- `ld_B`  out  1  loads the B operand/shift register.
- `add_en`  out  1  adds A into the accumulator this cycle.
- `shift_en`  out  1  shifts the accumulator:B pair right by one.
- `ld_out`  out  1  loads the 2*WIDTH-bit output register.

## Operation
- States: IDLE, LOAD, ADD, SHIFT, STORE, DONE. Step counter `cnt` is $clog2(WIDTH) bits wide.
- IDLE: all outputs 0. If `start`=1, go to LOAD; otherwise stay.
- LOAD: `ld_A`=`ld_B`=`clr_acc`=1 and `cnt`<=0. Then go to ADD.
- ADD: `add_en`=`b_lsb`, a Mealy output and the only one. Then go to SHIFT.
- SHIFT: `shift_en`=1.
  - If `cnt`==WIDTH-1, go to STORE.
  - Otherwise `cnt`<=`cnt`+1 and go to ADD.
- STORE: `ld_out`=1. Then go to DONE.
- DONE: `done`=1. Then go to IDLE unconditionally.
- All other outputs are Moore-decoded from the state. At most one of `add_en`/`shift_en` is high per cycle, except under the macro (see Configuration).
- `start` is ignored outside IDLE. If `start` is held high continuously, the block restarts back-to-back: DONE -> IDLE -> LOAD.
- Reset: state<=IDLE, `cnt`<=0, all outputs 0 in the following cycle.
  - Reset mid-operation aborts without `done` or `ld_out`.
  - Datapath contents are left as-is.
- `b_lsb` is sampled only in ADD. Changes in any other state have no effect.

## Timing
- Cycle 0 is the IDLE cycle in which `start`=1 is sampled.
- LOAD is cycle 1. ADD/SHIFT alternate over cycles 2..2*WIDTH+1. STORE is cycle 2*WIDTH+2. DONE is cycle 2*WIDTH+3.
- For WIDTH=4: `done` is high in cycle 11, and the next `start` can be sampled in cycle 12.
- `busy` is high in cycles 1..2*WIDTH+3 inclusive.
- The datapath is expected to present `b_lsb` in the cycle after `ld_B`/`shift_en` (registered).

## Configuration
- `MULT_CTRL_SKIP_ZERO_EN`
  - Defined: in ADD with `b_lsb`=0, the block asserts `shift_en` in the same cycle, applies the SHIFT terminal-count check and counter increment, and bypasses SHIFT. The next state is ADD or STORE.
  - Defined, latency: 2 cycles per 1-bit of B, 1 cycle per 0-bit. `done` lands at cycle 3+WIDTH+popcount(B).
  - Defined, with `b_lsb`=1: behaviour is unchanged.
  - Undefined: fixed latency 2*WIDTH+3 as described above.

## Test plan
- Reset: hold `rst` 2 cycles with `start`=1 -> all outputs 0 and `busy`=0. The first LOAD follows in the cycle after `rst` drops.
- Basic, WIDTH=4, A=1011, B=1101: `add_en` pattern over the ADD cycles = 1,0,1,1. `done` in cycle 11. Datapath output = 8'h8F (143).
- Zero operand, B=0000: `add_en` never asserts. `shift_en` pulses exactly 4 times. Output = 0. `done` in cycle 11.
- Back-to-back: `start` held high for 30 cycles -> `done` pulses in cycles 11 and 23. `start` is ignored while `busy`=1.
- Abort: assert `rst` in cycle 5 -> IDLE next cycle. No `ld_out` or `done`. A new `start` gives a normal full sequence.
- With `MULT_CTRL_SKIP_ZERO_EN`, B=0101: 6 ADD/SHIFT cycles. `done` in cycle 9. Product correct for A=1111 (8'h4B).
